// File: rtl/scroll_controller.sv
// rtl/scroll_controller.sv - paces the scroll message and presents each six-character HEX window with load strobes
module scroll_controller #(
  parameter int TICKS_PER_STEP = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       dir,
  output logic       hex_en,
  output logic       ledr_en,
  output logic [6:0] next_hex0,
  output logic [6:0] next_hex1,
  output logic [6:0] next_hex2,
  output logic [6:0] next_hex3,
  output logic [6:0] next_hex4,
  output logic [6:0] next_hex5
);

  localparam int CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICKS_PER_STEP - 1);

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_C   = 7'b1000110;
  localparam logic [6:0] HEX_P   = 7'b0001100;
  localparam logic [6:0] HEX_E   = 7'b0000110;
  localparam logic [6:0] HEX_N   = 7'b1001000;
  localparam logic [6:0] HEX_OFF = 7'b1111111;
  localparam logic [6:0] HEX_3   = 7'b0110000;
  localparam logic [6:0] HEX_1   = 7'b1111001;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_PAUSE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [2:0]      pos_q;
  logic [2:0]      pos_d;
  logic [41:0]     window_q;
  logic [41:0]     window_d;
  logic            hex_en_q;
  logic            ledr_en_q;

  function automatic logic [6:0] msg_char(input logic [2:0] idx);
    logic [6:0] c;
    case (idx)
      3'd0:    c = HEX_C;
      3'd1:    c = HEX_P;
      3'd2:    c = HEX_E;
      3'd3:    c = HEX_N;
      3'd4:    c = HEX_OFF;
      3'd5:    c = HEX_3;
      default: c = HEX_1;
    endcase
    return c;
  endfunction

  // Packed as {hex5..hex0}; hex5 shows msg[p], each lower digit the next message entry
  function automatic logic [41:0] window_at(input logic [2:0] p);
    logic [41:0] w;
    logic [2:0]  idx;
    w = '0;
    for (int k = 0; k < 6; k++) begin
      idx = p + 3'(k);
      w[(5-k)*7 +: 7] = msg_char(idx);
    end
    return w;
  endfunction

  always_comb begin
    pos_d    = dir ? pos_q + 3'd1 : pos_q - 3'd1;
    window_d = window_at(pos_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      count_q   <= '0;
      pos_q     <= 3'd0;
      window_q  <= {6{HEX_OFF}};
      hex_en_q  <= 1'b0;
      ledr_en_q <= 1'b0;
    end else begin
      hex_en_q  <= 1'b0;
      ledr_en_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          pos_q    <= 3'd0;
          count_q  <= '0;
          window_q <= window_at(3'd0);
          hex_en_q <= 1'b1;
          state_q  <= S_RUN;
        end
        S_RUN, S_PAUSE: begin
          // Pause outranks the terminal count; releasing resumes on the same edge
          if (pause) begin
            state_q <= S_PAUSE;
          end else begin
            state_q <= S_RUN;
            if (count_q == TERM) begin
              count_q   <= '0;
              pos_q     <= pos_d;
              window_q  <= window_d;
              hex_en_q  <= 1'b1;
              ledr_en_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign hex_en    = hex_en_q;
  assign ledr_en   = ledr_en_q;
  assign next_hex5 = window_q[41:35];
  assign next_hex4 = window_q[34:28];
  assign next_hex3 = window_q[27:21];
  assign next_hex2 = window_q[20:14];
  assign next_hex1 = window_q[13:7];
  assign next_hex0 = window_q[6:0];

endmodule

// File: tb/tb_scroll_controller.sv
// tb/tb_scroll_controller.sv - directed checks of scroll_controller windows, strobes, pause and reset
module tb_scroll_controller;

  localparam int TICKS = 4;

  localparam logic [6:0] S_C   = 7'b1000110;
  localparam logic [6:0] S_P   = 7'b0001100;
  localparam logic [6:0] S_E   = 7'b0000110;
  localparam logic [6:0] S_N   = 7'b1001000;
  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_1   = 7'b1111001;

  localparam logic [41:0] INIT_W = {S_C, S_P, S_E, S_N, S_OFF, S_3};
  localparam logic [41:0] R1_W   = {S_1, S_C, S_P, S_E, S_N, S_OFF};
  localparam logic [41:0] L1_W   = {S_P, S_E, S_N, S_OFF, S_3, S_1};
  localparam logic [41:0] OFF_W  = {6{S_OFF}};

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic       dir;
  logic       hex_en;
  logic       ledr_en;
  logic [6:0] next_hex0, next_hex1, next_hex2, next_hex3, next_hex4, next_hex5;
  logic [41:0] win_obs;
  logic [2:0]  cur_pos;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scroll_controller #(.TICKS_PER_STEP(TICKS)) dut (
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .dir       (dir),
    .hex_en    (hex_en),
    .ledr_en   (ledr_en),
    .next_hex0 (next_hex0),
    .next_hex1 (next_hex1),
    .next_hex2 (next_hex2),
    .next_hex3 (next_hex3),
    .next_hex4 (next_hex4),
    .next_hex5 (next_hex5)
  );

  assign win_obs = {next_hex5, next_hex4, next_hex3, next_hex2, next_hex1, next_hex0};

  function automatic logic [6:0] msg(input logic [2:0] i);
    logic [6:0] table_c [8];
    table_c = '{S_C, S_P, S_E, S_N, S_OFF, S_3, S_1, S_1};
    return table_c[i];
  endfunction

  function automatic logic [41:0] win(input logic [2:0] p);
    logic [41:0] w;
    logic [2:0]  idx;
    w = '0;
    for (int k = 0; k < 6; k++) begin
      idx = p + 3'(k);
      w[(5-k)*7 +: 7] = msg(idx);
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_step(input logic [2:0] nxt);
    for (int i = 1; i < TICKS; i++) begin
      tick();
      check("idle_strobes", 64'({hex_en, ledr_en}), 64'(2'b00));
      check("hold_window", 64'(win_obs), 64'(win(cur_pos)));
    end
    tick();
    check("step_strobes", 64'({hex_en, ledr_en}), 64'(2'b11));
    check("step_window", 64'(win_obs), 64'(win(nxt)));
    cur_pos = nxt;
  endtask

  initial begin
    reset = 1'b0;
    pause = 1'b0;
    dir   = 1'b0;
    cur_pos = 3'd0;
    repeat (3) tick();
    check("reset_window", 64'(win_obs), 64'(OFF_W));
    check("reset_strobes", 64'({hex_en, ledr_en}), 64'(2'b00));

    reset = 1'b1;
    tick();
    check("init_window", 64'(win_obs), 64'(INIT_W));
    check("init_hex_en", 64'(hex_en), 64'(1'b1));
    check("init_ledr_en", 64'(ledr_en), 64'(1'b0));

    run_step(3'd7);
    check("right_first", 64'(win_obs), 64'(R1_W));
    for (int s = 2; s <= 8; s++) run_step(cur_pos - 3'd1);
    check("right_wrap", 64'(win_obs), 64'(INIT_W));

    dir = 1'b1;
    run_step(3'd1);
    check("left_first", 64'(win_obs), 64'(L1_W));
    for (int s = 2; s <= 7; s++) run_step(cur_pos + 3'd1);
    check("left_pos7", 64'(win_obs), 64'(win(3'd7)));
    run_step(3'd0);
    check("left_wrap", 64'(win_obs), 64'(INIT_W));

    tick();
    tick();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pause_strobes", 64'({hex_en, ledr_en}), 64'(2'b00));
      check("pause_window", 64'(win_obs), 64'(INIT_W));
    end
    pause = 1'b0;
    tick();
    check("resume_no_step", 64'({hex_en, ledr_en}), 64'(2'b00));
    tick();
    check("resume_step", 64'({hex_en, ledr_en}), 64'(2'b11));
    check("resume_window", 64'(win_obs), 64'(win(3'd1)));
    cur_pos = 3'd1;

    tick();
    tick();
    tick();
    pause = 1'b1;
    tick();
    check("term_pause_strobes", 64'({hex_en, ledr_en}), 64'(2'b00));
    tick();
    check("term_pause_window", 64'(win_obs), 64'(win(3'd1)));
    pause = 1'b0;
    tick();
    check("term_release_step", 64'({hex_en, ledr_en}), 64'(2'b11));
    check("term_release_window", 64'(win_obs), 64'(win(3'd2)));
    cur_pos = 3'd2;

    run_step(3'd3);
    run_step(3'd4);
    run_step(3'd5);
    check("pre_reset_strobes", 64'({hex_en, ledr_en}), 64'(2'b11));
    #2 reset = 1'b0;
    #1;
    check("async_strobes", 64'({hex_en, ledr_en}), 64'(2'b00));
    check("async_window", 64'(win_obs), 64'(OFF_W));
    @(negedge clk);
    tick();
    check("held_reset_window", 64'(win_obs), 64'(OFF_W));
    reset = 1'b1;
    tick();
    check("reinit_window", 64'(win_obs), 64'(INIT_W));
    check("reinit_strobes", 64'({hex_en, ledr_en}), 64'(2'b10));
    tick();
    check("reinit_drop", 64'({hex_en, ledr_en}), 64'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
